// File: rtl/cache_types_pkg.sv
// Shared cache types: adaptor FSM state encoding, line/beat geometry and the
// beat-count derivation used by both the cache datapath and the line adaptor.
package cache_types_pkg;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BEATS   = LINE_W / BURST_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor: assembles BEATS memory beats into a fill
// line and serialises dirty lines to memory. Option: CACHELINE_ADAPTOR_ALIGN_EN.
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = cache_types_pkg::LINE_W,
    parameter int unsigned BURST_W = cache_types_pkg::BURST_W,
    parameter int unsigned ADDR_W  = cache_types_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);
    import cache_types_pkg::*;

    localparam int unsigned NBEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned IDX_W  = $clog2(LINE_W);

    adaptor_state_t     r_state;
    adaptor_state_t     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_off_inc;
    logic               w_last;
    logic [ADDR_W-1:0]  w_addr_cap;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  r_wline;
    logic [BURST_W-1:0] r_burst;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_read_o;
    logic               r_write_o;
    logic               r_resp_o;
    logic               w_read_nxt;
    logic               w_write_nxt;
    logic               w_resp_nxt;

    assign w_last    = (r_cnt == CNT_W'(NBEATS - 1));
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_cnt_nxt = w_last ? '0 : w_cnt_inc;
    assign w_off     = IDX_W'(r_cnt) * IDX_W'(BURST_W);
    assign w_off_inc = IDX_W'(w_cnt_inc) * IDX_W'(BURST_W);

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    assign w_addr_cap = address_i & ~ADDR_W'(LINE_W / 8 - 1);
`else
    assign w_addr_cap = address_i;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; write wins over read when both are requested
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state_nxt = WRITE;
                end else if (read_i) begin
                    w_state_nxt = READ;
                end
            end
            READ, WRITE: begin
                if (resp_i && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops
    always_comb begin
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_resp_nxt  = 1'b0;
        case (w_state_nxt)
            READ:    w_read_nxt  = 1'b1;
            WRITE:   w_write_nxt = 1'b1;
            DONE:    w_resp_nxt  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_o  <= 1'b0;
            r_write_o <= 1'b0;
            r_resp_o  <= 1'b0;
        end else begin
            r_read_o  <= w_read_nxt;
            r_write_o <= w_write_nxt;
            r_resp_o  <= w_resp_nxt;
        end
    end

    // Beat counter, fill assembly and write-back serialisation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_line  <= '0;
            r_wline <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_addr  <= w_addr_cap;
                        r_wline <= line_i;
                        r_burst <= line_i[BURST_W-1:0];
                        r_cnt   <= '0;
                    end else if (read_i) begin
                        r_addr <= w_addr_cap;
                        r_line <= '0;
                        r_cnt  <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line[w_off +: BURST_W] <= burst_i;
                        r_cnt                    <= w_cnt_nxt;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_cnt <= w_cnt_nxt;
                        if (!w_last) begin
                            r_burst <= r_wline[w_off_inc +: BURST_W];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign line_o    = r_line;
    assign burst_o   = r_burst;
    assign address_o = r_addr;
    assign read_o    = r_read_o;
    assign write_o   = r_write_o;
    assign resp_o    = r_resp_o;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table of fill/write-back vectors
// with a response scoreboard, plus reset and abort sequences.
module tb_cacheline_adaptor;
    import cache_types_pkg::*;

    localparam int unsigned CYC_MAX = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic [31:0]       ack;
    } vec_t;

    typedef struct {
        logic              is_rd;
        logic [LINE_W-1:0] line;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a);
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
        return a & ~ADDR_W'(LINE_W / 8 - 1);
`else
        return a;
`endif
    endfunction

    function automatic logic [BURST_W-1:0] slice(input logic [LINE_W-1:0] d, input int k);
        return BURST_W'(d >> (k * BURST_W));
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest request
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && resp_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_resp", LINE_W'(resp_o), LINE_W'(0));
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) check("line_o", line_o, e.line);
                check("resp_address_o", LINE_W'(address_o), LINE_W'(e.addr));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   k;
        int   c;
        logic is_rd;
        is_rd = v.rd && !v.wr;
        @(negedge clk);
        read_i    = v.rd;
        write_i   = v.wr;
        address_i = v.addr;
        line_i    = v.data;
        sb_q.push_back('{is_rd, v.data, exp_addr(v.addr)});
        k = 0;
        c = 0;
        @(negedge clk);
        while (k < int'(BEATS) && c < int'(CYC_MAX)) begin
            check("read_o", LINE_W'(read_o), LINE_W'(is_rd));
            check("write_o", LINE_W'(write_o), LINE_W'(!is_rd));
            check("resp_o_busy", LINE_W'(resp_o), LINE_W'(0));
            check("address_o", LINE_W'(address_o), LINE_W'(exp_addr(v.addr)));
            if (!is_rd) check("burst_o", LINE_W'(burst_o), LINE_W'(slice(v.data, k)));
            resp_i  = v.ack[c % 32];
            burst_i = is_rd ? slice(v.data, k) : 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            if (resp_i) k++;
            c++;
        end
        if (k < int'(BEATS)) check("beat_timeout", LINE_W'(k), LINE_W'(BEATS));
        resp_i = 1'b0;
        check("resp_o_pulse", LINE_W'(resp_o), LINE_W'(1));
        check("read_o_done", LINE_W'(read_o), LINE_W'(0));
        check("write_o_done", LINE_W'(write_o), LINE_W'(0));
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
        check("resp_o_single", LINE_W'(resp_o), LINE_W'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] held;
        rst_n     = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b1;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1040,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'hFFFF_FFFF};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2000,
                    {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                     64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 32'hFFFF_FFE5};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3000, rand_line(), 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_105C, rand_line(), 32'hFFFF_FFF6};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_4008, rand_line(), 32'hFFFF_FFFB};

        // Reset held with a read pending: nothing may start
        repeat (3) @(negedge clk);
        check("rst_read_o", LINE_W'(read_o), LINE_W'(0));
        check("rst_write_o", LINE_W'(write_o), LINE_W'(0));
        check("rst_resp_o", LINE_W'(resp_o), LINE_W'(0));
        check("rst_line_o", line_o, LINE_W'(0));
        check("rst_burst_o", LINE_W'(burst_o), LINE_W'(0));
        check("rst_address_o", LINE_W'(address_o), LINE_W'(0));
        read_i = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("idle_read_o", LINE_W'(read_o), LINE_W'(0));

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // line_o holds the last fill across a later write-back
        held = vecs[3].data;
        repeat (2) @(negedge clk);
        check("line_o_hold", line_o, held);

        // Abort a fill after two beats, then a clean fill
        @(negedge clk);
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
        @(negedge clk);
        resp_i = 1'b0;
        rst_n  = 1'b0;
        read_i = 1'b0;
        #1;
        check("abort_read_o", LINE_W'(read_o), LINE_W'(0));
        check("abort_resp_o", LINE_W'(resp_o), LINE_W'(0));
        check("abort_line_o", line_o, LINE_W'(0));
        check("abort_address_o", LINE_W'(address_o), LINE_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{1'b1, 1'b0, 32'h0000_6000, rand_line(), 32'hFFFF_FFFF});

        repeat (3) @(negedge clk);
        check("sb_drain", LINE_W'(sb_q.size()), LINE_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts between the cache's full-line interface and the narrow burst interface of physical memory. On a line fill it collects `BEATS` consecutive memory beats into one line and returns it to the cache datapath, which writes it into the cache data arrays; on a write-back it takes a dirty line read from those arrays and serialises it to memory beat by beat. It sits between the cache datapath and the memory port, one instance per cache.

## Interface
- `LINE_W`, 256, cache line width in bits.
- `BURST_W`, 64, memory beat width in bits; `LINE_W` must be an integer multiple; `BEATS = LINE_W/BURST_W`.
- `ADDR_W`, 32, address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `line_i`  in  LINE_W  line to write back; sampled at write accept.
- `line_o`  out  LINE_W  assembled fill line; valid when `resp_o` is 1.
- `address_i`  in  ADDR_W  line address; sampled at accept.
- `read_i`  in  1  fill request from the cache controller.
- `write_i`  in  1  write-back request from the cache controller.
- `resp_o`  out  1  one-cycle completion pulse.
- `burst_i`  in  BURST_W  memory read beat.
- `burst_o`  out  BURST_W  memory write beat.
- `address_o`  out  ADDR_W  address presented to memory.
- `read_o`  out  1  memory read request.
- `write_o`  out  1  memory write request.
- `resp_i`  in  1  memory beat acknowledge; one beat transferred per cycle it is 1.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: `write_i` = 1 → capture `address_i` and `line_i`, clear the beat counter, go to WRITE. Else `read_i` = 1 → capture `address_i`, clear the counter and the line register, go to READ. Write has priority when both are 1.
- READ: `read_o` = 1. On each cycle with `resp_i` = 1, store `burst_i` into slice `[cnt*BURST_W +: BURST_W]` of the line register and increment the counter. The beat with `cnt = BEATS-1` goes to DONE.
- WRITE: `write_o` = 1 and `burst_o` = slice `cnt` of the captured line. `resp_i` = 1 advances the counter. The last beat goes to DONE.
- DONE: `resp_o` = 1 for exactly one cycle, then IDLE. No new request is accepted in DONE.
- Gaps in `resp_i` during a burst stall the counter. The request line and current `burst_o` are held unchanged.
- The beat counter is `$clog2(BEATS)` bits. It wraps to 0 only together with the DONE transition.
- `resp_i` in IDLE or DONE is ignored. `read_i`/`write_i` while busy are ignored; the controller holds them until `resp_o`.
- `line_o` is driven from the line register and holds its value until the next read is accepted. It is undefined for write transactions; the bench must not check it there.
- `address_o` is driven from the captured address. It is stable for the whole transaction.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, counter 0, `resp_o`/`read_o`/`write_o` = 0, `line_o`/`burst_o`/`address_o` = 0.
- Reset asserted mid-burst aborts immediately: no `resp_o`, outputs go to reset values, and the partial line is discarded.
- Request accepted in cycle T → `read_o`/`write_o` high from T+1.
- With `resp_i` high on every cycle from T+1, the last beat lands at T+BEATS and `resp_o` pulses at T+BEATS+1. Minimum latency is BEATS+1 cycles.
- `read_o`/`write_o` deassert in the same cycle `resp_o` asserts.
- A new request can be accepted at the earliest in the cycle after `resp_o`.

## Configuration
- `CACHELINE_ADAPTOR_ALIGN_EN` defined: `address_o` has its low `$clog2(LINE_W/8)` bits forced to 0, giving a line-aligned memory address.
- Macro undefined: `address_o` is the captured `address_i` unmodified; the controller is responsible for alignment.

## Structure
- Shared `cache_types_pkg` holds:
  - the FSM state enum `adaptor_state_t`;
  - the `LINE_W`/`BURST_W` default constants;
  - the `BEATS` localparam derivation, so the cache datapath and this block agree.
- Single module. No sub-module: the counter and line register stay inline.

## Test plan
- Reset: hold `rst_n` = 0 and drive `read_i` → all outputs 0, no `read_o`. Release reset → IDLE.
- Fill: `read_i` with addr 0x0000_1040, `resp_i` high 4 cycles, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `resp_o` at accept+5. `line_o` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; `address_o` = 0x0000_1040.
- Write-back with stalls: `line_i` = {D3,D2,D1,D0}, `resp_i` pattern 1,0,1,0,0,1,1 → `burst_o` sequence D0,D1,D1,D2,D2,D2,D3, changing only after each acknowledged beat. `resp_o` one cycle after the last beat.
- Simultaneous `read_i` = `write_i` = 1 → `write_o` asserted, `read_o` stays 0.
- Reset mid-read after 2 beats, then a new fill → no `resp_o` for the aborted fill. The new fill returns only its own 4 beats.
- Alignment: addr 0x0000_105C → `address_o` = 0x0000_1040 with `CACHELINE_ADAPTOR_ALIGN_EN` defined, 0x0000_105C without.
